alu_ctrl_md: RTL

Parametrised ALU control decoder with a multiply/divide sequencer, for the MIPS datapath.
- Decodes `funct_i`/`ALUOp_i` into ALU control, jump-register and shift-select signals, as the existing single-cycle decoder does.
- Adds MULT/MULTU/DIV/DIVU/MFHI/MFLO support: a counter-based FSM launches a multi-cycle mul/div unit, tracks its completion and writes HI/LO.
- Interlocks dependent instructions with a stall to the PC/IF stage.

---
 rtl/alu_ctrl_md.sv | 130 +++++++++++++
 1 files changed

// File: rtl/alu_ctrl_md.sv
// ALU control decoder with a counter-based multiply/divide sequencer and HI/LO interlock.
// Optional mul/div support is built only when ALU_CTRL_MULDIV_EN is defined.
module alu_ctrl_md #(
   parameter int CTRL_W    = 5,
   parameter int MD_CYCLES = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   input  logic [5:0]        funct_i,
   input  logic [CTRL_W-1:0] ALUOp_i,
   input  logic              flush_i,
   output logic [CTRL_W-1:0] ALUCtrl_o,
   output logic              JR_o,
   output logic              SR_o,
   output logic              md_start_o,
   output logic [1:0]        md_op_o,
   output logic              md_busy_o,
   output logic              hilo_we_o,
   output logic              stall_o
);
   localparam logic [CTRL_W-1:0] C_ADD  = CTRL_W'(1);
   localparam logic [CTRL_W-1:0] C_ADDU = CTRL_W'(2);
   localparam logic [CTRL_W-1:0] C_SUB  = CTRL_W'(3);
   localparam logic [CTRL_W-1:0] C_AND  = CTRL_W'(4);
   localparam logic [CTRL_W-1:0] C_OR   = CTRL_W'(5);
   localparam logic [CTRL_W-1:0] C_XOR  = CTRL_W'(6);
   localparam logic [CTRL_W-1:0] C_NOR  = CTRL_W'(7);
   localparam logic [CTRL_W-1:0] C_NAND = CTRL_W'(8);
   localparam logic [CTRL_W-1:0] C_SLT  = CTRL_W'(9);
   localparam logic [CTRL_W-1:0] C_SLL  = CTRL_W'(10);
   localparam logic [CTRL_W-1:0] C_SRL  = CTRL_W'(11);
   localparam logic [CTRL_W-1:0] C_JR   = CTRL_W'(12);
   localparam logic [CTRL_W-1:0] C_SRA  = CTRL_W'(18);
`ifdef ALU_CTRL_MULDIV_EN
   localparam logic [CTRL_W-1:0] C_MFHI = CTRL_W'(19);
   localparam logic [CTRL_W-1:0] C_MFLO = CTRL_W'(20);
`endif

   always_comb begin
      ALUCtrl_o = ALUOp_i;
      JR_o      = 1'b0;
      SR_o      = 1'b0;
      if (ALUOp_i == '0) begin
         case (funct_i)
            6'h20: ALUCtrl_o = C_ADD;
            6'h21: ALUCtrl_o = C_ADDU;
            6'h22: ALUCtrl_o = C_SUB;
            6'h24: ALUCtrl_o = C_AND;
            6'h25: ALUCtrl_o = C_OR;
            6'h26: ALUCtrl_o = C_XOR;
            6'h27: ALUCtrl_o = C_NOR;
            6'h28: ALUCtrl_o = C_NAND;
            6'h2A: ALUCtrl_o = C_SLT;
            6'h00: begin ALUCtrl_o = C_SLL; SR_o = 1'b1; end
            6'h02: begin ALUCtrl_o = C_SRL; SR_o = 1'b1; end
            6'h03: begin ALUCtrl_o = C_SRA; SR_o = 1'b1; end
            6'h08: begin ALUCtrl_o = C_JR;  JR_o = 1'b1; end
`ifdef ALU_CTRL_MULDIV_EN
            6'h10: ALUCtrl_o = C_MFHI;
            6'h12: ALUCtrl_o = C_MFLO;
            6'h18, 6'h19, 6'h1A, 6'h1B: ALUCtrl_o = '0;
`endif
            default: ;
         endcase
      end
   end

`ifdef ALU_CTRL_MULDIV_EN
   localparam int CNT_W = $clog2(MD_CYCLES + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             r_type;
   logic             md_op;
   logic             hilo_user;
   logic             launch;

   assign r_type    = (ALUOp_i == '0);
   assign md_op     = valid_i && r_type && (funct_i[5:2] == 4'b0110);
   assign hilo_user = md_op || (valid_i && r_type && (funct_i == 6'h10 || funct_i == 6'h12));
   assign launch    = (state == IDLE) && md_op && !flush_i;

   // Reset only masks the launch pulse; the flops never see rst_i as data.
   assign md_start_o = rst_i && launch;
   assign md_op_o    = md_start_o ? funct_i[1:0] : 2'b00;
   assign md_busy_o  = (state == BUSY);
   assign hilo_we_o  = (state == BUSY) && (cnt == '0) && !flush_i;
   assign stall_o    = (state == BUSY) && hilo_user;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (launch) begin
                  state <= BUSY;
                  cnt   <= CNT_W'(MD_CYCLES - 1);
               end
            end
            BUSY: begin
               // Flush wins over completion: no HI/LO write for a cancelled op.
               if (flush_i || cnt == '0) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end
`else
   logic unused_md;
   assign unused_md  = ^{clk_i, rst_i, valid_i, flush_i};
   assign md_start_o = 1'b0;
   assign md_op_o    = 2'b00;
   assign md_busy_o  = 1'b0;
   assign hilo_we_o  = 1'b0;
   assign stall_o    = 1'b0;
`endif
endmodule
